frame_slot_arbiter: RTL and testbench

//  Single-clock frame-slot manager for DDR video frame buffers. It hands out frame base

---
 rtl/frame_slot_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_frame_slot_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_slot_arbiter.sv
// Frame-slot manager for DDR video frame buffers: hands out write/read base addresses
// and tracks per-slot ownership in LATEST (drop stale) or QUEUE (lossless) mode.
module frame_slot_arbiter #(
    parameter int unsigned START_ADDR    = 0,
    parameter int unsigned FRAMES_AMOUNT = 3,
    parameter int unsigned FRAME_RES_X   = 1920,
    parameter int unsigned FRAME_RES_Y   = 1080,
    parameter int unsigned TDATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter bit          CAPTURE_EN    = 1'b0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   mode_i,
    input  logic                                   freeze_i,
    input  logic                                   wr_req_i,
    output logic                                   wr_gnt_o,
    output logic [ADDR_WIDTH-1:0]                  wr_addr_o,
    input  logic                                   wr_done_stb_i,
    input  logic                                   rd_req_i,
    output logic                                   rd_gnt_o,
    output logic [ADDR_WIDTH-1:0]                  rd_addr_o,
    output logic                                   rd_new_o,
    input  logic                                   rd_done_stb_i,
    output logic [$clog2(FRAMES_AMOUNT+1)-1:0]     ready_frames_o,
    output logic [CNT_WIDTH-1:0]                   dropped_o,
    output logic [CNT_WIDTH-1:0]                   repeated_o,
    output logic                                   proto_err_o
);

    localparam int unsigned IW  = $clog2(FRAMES_AMOUNT);
    localparam int unsigned RW  = $clog2(FRAMES_AMOUNT + 1);
    localparam int unsigned BPP = (TDATA_WIDTH <= 8)  ? 1 :
                                  (TDATA_WIDTH <= 16) ? 2 :
                                  (TDATA_WIDTH <= 32) ? 4 : 8;

    typedef longint unsigned u64_t;
    localparam u64_t FRAME_BYTES = u64_t'(FRAME_RES_X) * u64_t'(FRAME_RES_Y) * u64_t'(BPP);

    typedef enum logic [2:0] {
        S_FREE,
        S_WRITING,
        S_READY,
        S_READING,
        S_HELD
    } slot_st_e;

    // Per-slot base addresses are elaboration-time constants.
    logic [ADDR_WIDTH-1:0] slot_base [FRAMES_AMOUNT];
    for (genvar g = 0; g < FRAMES_AMOUNT; g++) begin : g_base
        assign slot_base[g] = ADDR_WIDTH'(u64_t'(START_ADDR) + u64_t'(g) * FRAME_BYTES);
    end

    slot_st_e              st_q   [FRAMES_AMOUNT];
    slot_st_e              st_d   [FRAMES_AMOUNT];
    logic [IW-1:0]         fifo_q [FRAMES_AMOUNT];
    logic [IW-1:0]         fifo_d [FRAMES_AMOUNT];
    logic [RW-1:0]         cnt_q, cnt_d;
    logic                  wr_gnt_q, wr_gnt_d;
    logic                  rd_gnt_q, rd_gnt_d;
    logic                  rd_new_q, rd_new_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_WIDTH-1:0]  dropped_q, dropped_d;
    logic [CNT_WIDTH-1:0]  repeated_q, repeated_d;
    logic                  perr_q, perr_d;

    logic                  freeze;
    logic                  wr_busy, rd_busy, held_vld, free_vld;
    logic [IW-1:0]         wr_idx, rd_idx, held_idx, free_idx, newest, take;

    assign freeze = CAPTURE_EN & freeze_i;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [RW-1:0]        b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Descending scan so the lowest-index FREE slot wins.
    always_comb begin
        wr_busy  = 1'b0;
        wr_idx   = '0;
        rd_busy  = 1'b0;
        rd_idx   = '0;
        held_vld = 1'b0;
        held_idx = '0;
        free_vld = 1'b0;
        free_idx = '0;
        newest   = '0;
        for (int i = FRAMES_AMOUNT - 1; i >= 0; i--) begin
            case (st_q[i])
                S_WRITING: begin wr_busy  = 1'b1; wr_idx   = IW'(i); end
                S_READING: begin rd_busy  = 1'b1; rd_idx   = IW'(i); end
                S_HELD:    begin held_vld = 1'b1; held_idx = IW'(i); end
                S_FREE:    begin free_vld = 1'b1; free_idx = IW'(i); end
                default: ;
            endcase
            if (RW'(i) == cnt_q - 1'b1) newest = fifo_q[i];
        end
    end

    always_comb begin
        st_d       = st_q;
        fifo_d     = fifo_q;
        cnt_d      = cnt_q;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_new_d   = rd_new_q;
        dropped_d  = dropped_q;
        repeated_d = repeated_q;
        perr_d     = perr_q;
        take       = '0;

        if (rd_done_stb_i) begin
            if (rd_busy) st_d[rd_idx] = S_HELD;
            else         perr_d = 1'b1;
        end

        // Reader decides first; a READING slot blocks a same-cycle request.
        if (rd_req_i && !rd_busy) begin
            if (cnt_q != '0) begin
                take = mode_i ? fifo_q[0] : newest;
                if (held_vld) st_d[held_idx] = S_FREE;
                st_d[take] = S_READING;
                if (mode_i) begin
                    for (int i = 0; i < FRAMES_AMOUNT - 1; i++) fifo_d[i] = fifo_d[i + 1];
                end
                cnt_d     = cnt_d - 1'b1;
                rd_gnt_d  = 1'b1;
                rd_addr_d = slot_base[take];
                rd_new_d  = 1'b1;
            end else if (held_vld) begin
                st_d[held_idx] = S_READING;
                rd_gnt_d       = 1'b1;
                rd_addr_d      = slot_base[held_idx];
                rd_new_d       = 1'b0;
                repeated_d     = sat_add(repeated_q, RW'(1));
            end
        end

        if (wr_req_i && !wr_busy && !freeze) begin
            if (free_vld) begin
                st_d[free_idx] = S_WRITING;
                wr_gnt_d       = 1'b1;
                wr_addr_d      = slot_base[free_idx];
            end else if (!mode_i && cnt_d != '0) begin
                // Evict the oldest READY frame still queued after the reader's pick.
                st_d[fifo_d[0]] = S_WRITING;
                wr_gnt_d        = 1'b1;
                wr_addr_d       = slot_base[fifo_d[0]];
                for (int i = 0; i < FRAMES_AMOUNT - 1; i++) fifo_d[i] = fifo_d[i + 1];
                cnt_d     = cnt_d - 1'b1;
                dropped_d = sat_add(dropped_d, RW'(1));
            end
        end

        if (wr_done_stb_i) begin
            if (wr_busy) begin
                if (!mode_i) begin
                    for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                        if (RW'(i) < cnt_d) st_d[fifo_d[i]] = S_FREE;
                    end
                    dropped_d = sat_add(dropped_d, cnt_d);
                    cnt_d     = '0;
                end
                for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                    if (RW'(i) == cnt_d) fifo_d[i] = wr_idx;
                end
                cnt_d        = cnt_d + 1'b1;
                st_d[wr_idx] = S_READY;
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                st_q[i]   <= S_FREE;
                fifo_q[i] <= '0;
            end
            cnt_q      <= '0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            rd_new_q   <= 1'b0;
            wr_addr_q  <= ADDR_WIDTH'(START_ADDR);
            rd_addr_q  <= ADDR_WIDTH'(START_ADDR);
            dropped_q  <= '0;
            repeated_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            fifo_q     <= fifo_d;
            cnt_q      <= cnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_new_q   <= rd_new_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            dropped_q  <= dropped_d;
            repeated_q <= repeated_d;
            perr_q     <= perr_d;
        end
    end

    assign wr_gnt_o       = wr_gnt_q;
    assign wr_addr_o      = wr_addr_q;
    assign rd_gnt_o       = rd_gnt_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_new_o       = rd_new_q;
    assign ready_frames_o = cnt_q;
    assign dropped_o      = dropped_q;
    assign repeated_o     = repeated_q;
    assign proto_err_o    = perr_q;

    // Ownership invariants: single writer/reader/held slot, FIFO depth tracks READY slots.
    int n_wr, n_rd, n_hd, n_rdy;
    always_comb begin
        n_wr  = 0;
        n_rd  = 0;
        n_hd  = 0;
        n_rdy = 0;
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            n_wr  += int'(st_q[i] == S_WRITING);
            n_rd  += int'(st_q[i] == S_READING);
            n_hd  += int'(st_q[i] == S_HELD);
            n_rdy += int'(st_q[i] == S_READY);
        end
    end

    a_single_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        n_wr <= 1 && n_rd + n_hd <= 1);
    a_fifo_depth: assert property (@(posedge clk_i) disable iff (rst_i)
        n_rdy == int'(cnt_q));

endmodule

// File: tb/tb_frame_slot_arbiter.sv
// Randomized bench for frame_slot_arbiter: queue-based slot model checked every cycle,
// plus directed scenarios with hand-computed addresses and counter values.
module tb_frame_slot_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int RW = $clog2(N + 1);
    localparam logic [AW-1:0] FB = 1920 * 1080 * 2;

    logic clk = 1'b0;
    logic rst = 1'b1, mode = 1'b0, freeze = 1'b0;
    logic wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0, rd_done = 1'b0;
    logic wr_gnt, rd_gnt, rd_new, perr;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [RW-1:0] ready;
    logic [CW-1:0] dropped, repeated;

    always #5 clk = ~clk;

    frame_slot_arbiter #(
        .START_ADDR(0), .FRAMES_AMOUNT(N), .FRAME_RES_X(1920), .FRAME_RES_Y(1080),
        .TDATA_WIDTH(16), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .CAPTURE_EN(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .freeze_i(freeze),
        .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_o(wr_addr), .wr_done_stb_i(wr_done),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_o(rd_addr), .rd_new_o(rd_new),
        .rd_done_stb_i(rd_done), .ready_frames_o(ready), .dropped_o(dropped),
        .repeated_o(repeated), .proto_err_o(perr)
    );

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot model: owners as indices, READY frames as an ordered queue.
    int m_wr, m_rd, m_held;
    int m_rdy[$];
    logic e_wg, e_rg, e_new, e_err;
    logic [AW-1:0] e_waddr, e_raddr;
    int e_drop, e_rep;
    bit mdl_on = 0;

    function automatic logic [AW-1:0] base(input int i);
        return AW'(i) * FB;
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    always @(posedge clk) begin : mdl
        int w, r, h, pick, f;
        int snap[$];
        bit inq;
        if (rst) begin
            mdl_on = 1;
            m_wr = -1; m_rd = -1; m_held = -1;
            m_rdy.delete();
            e_wg = 0; e_rg = 0; e_new = 0; e_err = 0;
            e_waddr = 0; e_raddr = 0; e_drop = 0; e_rep = 0;
        end else begin
            w = m_wr; r = m_rd; h = m_held; snap = m_rdy;
            e_wg = 0; e_rg = 0;
            if (rd_done) begin
                if (r >= 0) begin m_held = r; m_rd = -1; end
                else e_err = 1;
            end
            if (rd_req && r < 0) begin
                if (snap.size() > 0) begin
                    pick = mode ? m_rdy.pop_front() : m_rdy.pop_back();
                    m_rd = pick; m_held = -1;
                    e_rg = 1; e_new = 1; e_raddr = base(pick);
                end else if (h >= 0) begin
                    m_rd = h; m_held = -1;
                    e_rg = 1; e_new = 0; e_raddr = base(h); e_rep = sat(e_rep + 1);
                end
            end
            if (wr_req && w < 0 && !freeze) begin
                f = -1;
                for (int i = N - 1; i >= 0; i--) begin
                    inq = 0;
                    foreach (snap[k]) if (snap[k] == i) inq = 1;
                    if (i != r && i != h && !inq) f = i;
                end
                if (f >= 0) begin
                    m_wr = f; e_wg = 1; e_waddr = base(f);
                end else if (!mode && m_rdy.size() > 0) begin
                    pick = m_rdy.pop_front();
                    m_wr = pick; e_wg = 1; e_waddr = base(pick); e_drop = sat(e_drop + 1);
                end
            end
            if (wr_done) begin
                if (w >= 0) begin
                    if (!mode) begin
                        e_drop = sat(e_drop + m_rdy.size());
                        m_rdy.delete();
                    end
                    m_rdy.push_back(w);
                    m_wr = -1;
                end else e_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("wr_gnt", wr_gnt, e_wg);
            chk("wr_addr", wr_addr, e_waddr);
            chk("rd_gnt", rd_gnt, e_rg);
            chk("rd_addr", rd_addr, e_raddr);
            chk("rd_new", rd_new, e_new);
            chk("ready_frames", ready, m_rdy.size());
            chk("dropped", dropped, e_drop);
            chk("repeated", repeated, e_rep);
            chk("proto_err", perr, e_err);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0; freeze = 0;
        tick(2);
        rst = 0;
    endtask

    task automatic wr_grant(output logic [AW-1:0] a);
        bit got = 0;
        wr_req = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wr_gnt) begin got = 1; break; end
        end
        wr_req = 0;
        a = wr_addr;
        chk("wr_grant_wait", got, 1);
    endtask

    task automatic rd_grant(output logic [AW-1:0] a, output logic nw);
        bit got = 0;
        rd_req = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rd_gnt) begin got = 1; break; end
        end
        rd_req = 0;
        a = rd_addr; nw = rd_new;
        chk("rd_grant_wait", got, 1);
    endtask

    task automatic wr_finish(); wr_done = 1; tick(); wr_done = 0; endtask
    task automatic rd_finish(); rd_done = 1; tick(); rd_done = 0; endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic nw;
        bit seen, w_own, r_own;
        int w_left, r_left;

        // T1: reset state, grant latency, first two write addresses
        do_reset();
        chk("t1_rst_wr_addr", wr_addr, 0);
        chk("t1_rst_rd_addr", rd_addr, 0);
        chk("t1_rst_ready", ready, 0);
        chk("t1_rst_gnt", {wr_gnt, rd_gnt, rd_new, perr}, 0);
        wr_req = 1; tick();
        chk("t1_gnt_latency", wr_gnt, 1);
        chk("t1_addr0", wr_addr, 0);
        wr_req = 0; tick();
        chk("t1_gnt_pulse", wr_gnt, 0);
        wr_finish();
        chk("t1_ready1", ready, 1);
        wr_grant(a);
        chk("t1_addr1", a, 64'h3F4800);

        // T2: LATEST drops stale frames
        do_reset(); mode = 0;
        wr_grant(a); chk("t2_f1_addr", a, 0); wr_finish();
        wr_grant(a); chk("t2_f2_addr", a, FB); wr_finish();
        wr_grant(a); chk("t2_f3_addr", a, 0); wr_finish();
        chk("t2_dropped", dropped, 2);
        chk("t2_ready", ready, 1);
        rd_grant(a, nw);
        chk("t2_rd_addr", a, 0);
        chk("t2_rd_new", nw, 1);

        // T3: QUEUE back-pressure and oldest-first reads
        do_reset(); mode = 1;
        for (int i = 0; i < N; i++) begin
            wr_grant(a); chk("t3_fill_addr", a, base(i)); wr_finish();
        end
        chk("t3_ready_full", ready, 3);
        wr_req = 1; seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); seen |= wr_gnt; end
        chk("t3_backpressure", seen, 0);
        rd_grant(a, nw);
        chk("t3_rd_oldest", a, 0);
        rd_finish();
        rd_grant(a, nw);
        chk("t3_rd_second", a, FB);
        tick();
        chk("t3_wr_release", wr_gnt, 1);
        chk("t3_wr_release_addr", wr_addr, 0);
        wr_req = 0;
        chk("t3_dropped", dropped, 0);

        // T4: underrun repeats the held frame
        do_reset(); mode = 0;
        wr_grant(a); wr_finish();
        rd_grant(a, nw); chk("t4_rd1_new", nw, 1);
        rd_finish();
        rd_grant(a, nw);
        chk("t4_rep_addr", a, 0);
        chk("t4_rep_new", nw, 0);
        chk("t4_repeated", repeated, 1);

        // T5: same-cycle wr_done + rd_req, then freeze
        do_reset(); mode = 0;
        wr_grant(a); wr_finish();
        rd_grant(a, nw); rd_finish();
        wr_grant(a); chk("t5_wr_addr", a, FB);
        wr_done = 1; rd_req = 1; tick();
        chk("t5_rep_gnt", rd_gnt, 1);
        chk("t5_rep_new", rd_new, 0);
        chk("t5_rep_addr", rd_addr, 0);
        wr_done = 0; rd_req = 0;
        chk("t5_ready", ready, 1);
        rd_finish();
        rd_grant(a, nw);
        chk("t5_new_addr", a, FB);
        chk("t5_new_flag", nw, 1);
        freeze = 1; wr_req = 1; seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); seen |= wr_gnt; end
        chk("t5_freeze_no_gnt", seen, 0);
        freeze = 0; tick();
        chk("t5_unfreeze_gnt", wr_gnt, 1);
        chk("t5_unfreeze_addr", wr_addr, 0);
        wr_req = 0;

        // T6: stray done flags error; reset mid-frame clears everything
        do_reset(); mode = 0;
        rd_done = 1; tick(); rd_done = 0;
        chk("t6_proto_err", perr, 1);
        wr_grant(a); wr_finish();
        wr_grant(a); wr_finish();
        rd_grant(a, nw); chk("t6_rd_addr", a, FB);
        wr_grant(a);
        rst = 1; tick();
        chk("t6_rst_gnt", {wr_gnt, rd_gnt, rd_new, perr}, 0);
        chk("t6_rst_addr", {wr_addr, rd_addr}, 0);
        chk("t6_rst_ready", ready, 0);
        chk("t6_rst_cnt", {dropped, repeated}, 0);
        rst = 0;

        // Randomized traffic with mode/freeze toggles, stray strobes and resets
        do_reset();
        w_own = 0; r_own = 0; w_left = 0; r_left = 0;
        for (int c = 0; c < 6000; c++) begin
            wr_done = 0; rd_done = 0;
            if (c % 700 == 699) begin
                rst = 1; wr_req = 0; rd_req = 0; w_own = 0; r_own = 0;
            end else begin
                rst = 0;
                if (!w_own && $urandom_range(0, 499) == 0) wr_done = 1;
                if (!r_own && $urandom_range(0, 499) == 0) rd_done = 1;
                if (wr_req && wr_gnt) begin
                    wr_req = 0; w_own = 1; w_left = $urandom_range(0, 3);
                end else if (w_own) begin
                    if (w_left == 0) begin wr_done = 1; w_own = 0; end
                    else w_left--;
                end else if (!wr_req && $urandom_range(0, 3) == 0) wr_req = 1;
                if (rd_req && rd_gnt) begin
                    rd_req = 0; r_own = 1; r_left = $urandom_range(0, 5);
                end else if (r_own) begin
                    if (r_left == 0) begin
                        rd_done = 1; r_own = 0; rd_req = ($urandom_range(0, 2) == 0);
                    end else r_left--;
                end else if (!rd_req && $urandom_range(0, 3) == 0) rd_req = 1;
                if ($urandom_range(0, 149) == 0) mode = ~mode;
                if ($urandom_range(0, 79) == 0) freeze = ~freeze;
            end
            tick();
        end
        rst = 0; wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
